// File: rtl/mdu_seq_if.sv
// Pipeline <-> MDU sequencer handshake bundle.
// The master side is the decode/execute stage; the slave side is mdu_seq.
interface mdu_seq_if;
  logic        op_valid;
  logic [2:0]  op;
  logic        flush;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [2:0]  mdu_ctrl;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall;
  logic        done;
  logic        div0;

  modport master (
    output op_valid, op, flush, a_in, b_in,
    input  mdu_ctrl, src_a, src_b, busy, stall, done, div0
  );

  modport slave (
    input  op_valid, op, flush, a_in, b_in,
    output mdu_ctrl, src_a, src_b, busy, stall, done, div0
  );
endinterface

// File: rtl/mdu_seq.sv
// Multicycle sequencer for the multiply/divide unit: holds operands and opcode
// stable for MULT_LAT/DIV_LAT cycles and stalls the pipeline meanwhile.
module mdu_seq #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 16
) (
  input logic      clk,
  input logic      reset,
  mdu_seq_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] MULT_CNT = 8'(MULT_LAT - 1);
  localparam logic [7:0] DIV_CNT  = 8'(DIV_LAT - 1);
  localparam logic [2:0] OP_IDLE  = 3'b100;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;
  logic        accept;
  logic        div_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    accept   = bus.op_valid & ~bus.flush & (state_q == IDLE);
    div_zero = (bus.op[2:1] == 2'b01) && (bus.b_in == '0);
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    div0_d   = accept & div_zero;
    if (state_q == IDLE) begin
      // Divide by zero is swallowed here: it never reaches the MDU, so HI/LO stay intact.
      if (accept && !bus.op[2] && !div_zero) begin
        state_d = BUSY;
        op_d    = bus.op;
        a_d     = bus.a_in;
        b_d     = bus.b_in;
        cnt_d   = bus.op[1] ? DIV_CNT : MULT_CNT;
      end
    end else begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_comb begin
    bus.busy  = (state_q == BUSY);
    bus.stall = bus.op_valid & ~bus.flush & (state_q == BUSY);
    bus.done  = done_q;
    bus.div0  = div0_q;
    if (state_q == BUSY) begin
      bus.mdu_ctrl = op_q;
      bus.src_a    = a_q;
      bus.src_b    = b_q;
    end else begin
      bus.mdu_ctrl = (accept && bus.op[2]) ? bus.op : OP_IDLE;
      bus.src_a    = bus.a_in;
      bus.src_b    = bus.b_in;
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural HI/LO MDU driven by the DUT outputs.
module tb_mdu_seq;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mdu_seq_if bus1 ();
  mdu_seq_if bus2 ();

  mdu_seq #(.MULT_LAT(4), .DIV_LAT(16)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  mdu_seq #(.MULT_LAT(1), .DIV_LAT(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MDU on dut1: captures every edge according to mdu_ctrl.
  logic [31:0] hi, lo;
  logic [31:0] mdu_res;
  initial begin hi = '0; lo = '0; end
  always @(posedge clk) begin
    longint      sa, sb;
    logic [63:0] p;
    int          da, db;
    case (bus1.mdu_ctrl)
      3'b000: begin
        sa = longint'($signed(bus1.src_a));
        sb = longint'($signed(bus1.src_b));
        p  = 64'(sa * sb);
        hi <= p[63:32]; lo <= p[31:0];
      end
      3'b001: begin
        p  = {32'b0, bus1.src_a} * {32'b0, bus1.src_b};
        hi <= p[63:32]; lo <= p[31:0];
      end
      3'b010: if (bus1.src_b != 0) begin
        da = $signed(bus1.src_a);
        db = $signed(bus1.src_b);
        lo <= 32'(da / db); hi <= 32'(da % db);
      end
      3'b011: if (bus1.src_b != 0) begin
        lo <= bus1.src_a / bus1.src_b; hi <= bus1.src_a % bus1.src_b;
      end
      3'b101: hi <= bus1.src_a;
      3'b111: lo <= bus1.src_a;
      default: ;
    endcase
  end
  assign mdu_res = (bus1.mdu_ctrl == 3'b110) ? lo : hi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drv1(input logic v, input logic [2:0] o, input logic f,
                      input logic [31:0] a, input logic [31:0] b);
    bus1.op_valid = v; bus1.op = o; bus1.flush = f; bus1.a_in = a; bus1.b_in = b;
  endtask

  task automatic drv2(input logic v, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b);
    bus2.op_valid = v; bus2.op = o; bus2.flush = 1'b0; bus2.a_in = a; bus2.b_in = b;
  endtask

  // Advance to just after the next rising edge; inputs are driven then, outputs sampled #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drv1(1'b1, 3'b000, 1'b0, 32'h0000_0055, 32'h0000_0066);
    drv2(1'b0, 3'b100, '0, '0);
    #2;
    check("rst_busy", 32'(bus1.busy), 32'd0);
    check("rst_stall", 32'(bus1.stall), 32'd0);
    check("rst_ctrl", 32'(bus1.mdu_ctrl), 32'd4);
    check("rst_src_a", bus1.src_a, 32'h0000_0055);
    check("rst_src_b", bus1.src_b, 32'h0000_0066);
    check("rst_done", 32'(bus1.done), 32'd0);
    check("rst_div0", 32'(bus1.div0), 32'd0);
    drv1(1'b0, 3'b100, 1'b0, '0, '0);
    tick();
    reset = 1'b0;

    // mult -2 * 3 with MULT_LAT=4
    tick();
    drv1(1'b1, 3'b000, 1'b0, 32'hFFFF_FFFE, 32'd3);
    #1;
    check("mul_c0_stall", 32'(bus1.stall), 32'd0);
    check("mul_c0_ctrl", 32'(bus1.mdu_ctrl), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      drv1(1'b0, 3'b100, 1'b0, 32'hDEAD_0000 + 32'(i), 32'hBEEF_0000);
      #1;
      check("mul_busy", 32'(bus1.busy), 32'd1);
      check("mul_ctrl", 32'(bus1.mdu_ctrl), 32'd0);
      check("mul_src_a", bus1.src_a, 32'hFFFF_FFFE);
      check("mul_src_b", bus1.src_b, 32'd3);
      check("mul_done_early", 32'(bus1.done), 32'd0);
    end
    tick();
    drv1(1'b1, 3'b110, 1'b0, '0, '0);
    #1;
    check("mul_c5_busy", 32'(bus1.busy), 32'd0);
    check("mul_c5_done", 32'(bus1.done), 32'd1);
    check("mul_c5_ctrl", 32'(bus1.mdu_ctrl), 32'd6);
    check("mul_mflo", mdu_res, 32'hFFFF_FFFA);
    tick();
    drv1(1'b1, 3'b100, 1'b0, '0, '0);
    #1;
    check("mul_c6_done", 32'(bus1.done), 32'd0);
    check("mul_mfhi", mdu_res, 32'hFFFF_FFFF);

    // divu 100/7 with mfhi stalled behind it
    tick();
    drv1(1'b1, 3'b011, 1'b0, 32'd100, 32'd7);
    for (int i = 1; i <= 16; i++) begin
      tick();
      drv1(1'b1, 3'b100, 1'b0, '0, '0);
      #1;
      check("div_stall", 32'(bus1.stall), 32'd1);
      check("div_ctrl", 32'(bus1.mdu_ctrl), 32'd3);
      check("div_done_early", 32'(bus1.done), 32'd0);
    end
    tick();
    drv1(1'b1, 3'b100, 1'b0, '0, '0);
    #1;
    check("div_c17_stall", 32'(bus1.stall), 32'd0);
    check("div_c17_ctrl", 32'(bus1.mdu_ctrl), 32'd4);
    check("div_c17_done", 32'(bus1.done), 32'd1);
    check("div_mfhi", mdu_res, 32'd2);
    tick();
    drv1(1'b1, 3'b110, 1'b0, '0, '0);
    #1;
    check("div_mflo", mdu_res, 32'd14);

    // mthi then div by zero
    tick();
    drv1(1'b1, 3'b101, 1'b0, 32'h0000_1234, '0);
    #1;
    check("mthi_ctrl", 32'(bus1.mdu_ctrl), 32'd5);
    tick();
    drv1(1'b1, 3'b010, 1'b0, 32'd5, 32'd0);
    #1;
    check("dz_stall", 32'(bus1.stall), 32'd0);
    check("dz_ctrl", 32'(bus1.mdu_ctrl), 32'd4);
    check("dz_div0_early", 32'(bus1.div0), 32'd0);
    tick();
    drv1(1'b1, 3'b100, 1'b0, '0, '0);
    #1;
    check("dz_div0", 32'(bus1.div0), 32'd1);
    check("dz_busy", 32'(bus1.busy), 32'd0);
    check("dz_mfhi", mdu_res, 32'h0000_1234);
    tick();
    drv1(1'b0, 3'b100, 1'b0, '0, '0);
    #1;
    check("dz_div0_clr", 32'(bus1.div0), 32'd0);

    // flush with a presented mult, then flush during a busy div
    tick();
    drv1(1'b1, 3'b000, 1'b1, 32'd7, 32'd9);
    #1;
    check("fl_stall", 32'(bus1.stall), 32'd0);
    check("fl_ctrl", 32'(bus1.mdu_ctrl), 32'd4);
    tick();
    drv1(1'b0, 3'b100, 1'b0, '0, '0);
    #1;
    check("fl_busy", 32'(bus1.busy), 32'd0);
    tick();
    drv1(1'b1, 3'b010, 1'b0, 32'd50, 32'd5);
    for (int i = 1; i <= 16; i++) begin
      tick();
      drv1(1'b1, 3'b000, 1'b1, '0, '0);
      #1;
      check("flb_busy", 32'(bus1.busy), 32'd1);
      check("flb_stall", 32'(bus1.stall), 32'd0);
    end
    tick();
    drv1(1'b1, 3'b110, 1'b0, '0, '0);
    #1;
    check("flb_done", 32'(bus1.done), 32'd1);
    check("flb_mflo", mdu_res, 32'd10);

    // reset in cycle 3 of a div
    tick();
    drv1(1'b1, 3'b010, 1'b0, 32'd9, 32'd2);
    tick();
    drv1(1'b0, 3'b100, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rmo_busy", 32'(bus1.busy), 32'd0);
    check("rmo_ctrl", 32'(bus1.mdu_ctrl), 32'd4);
    check("rmo_done", 32'(bus1.done), 32'd0);
    #2;
    reset = 1'b0;
    tick();
    drv1(1'b1, 3'b001, 1'b0, 32'd6, 32'd7);
    #1;
    check("rmo_stall", 32'(bus1.stall), 32'd0);
    tick();
    drv1(1'b0, 3'b100, 1'b0, '0, '0);
    #1;
    check("rmo_mul_busy", 32'(bus1.busy), 32'd1);
    check("rmo_mul_ctrl", 32'(bus1.mdu_ctrl), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    #1;
    check("rmo_mul_lo", lo, 32'd42);

    // MULT_LAT=1 back-to-back mult, mult on dut2
    tick();
    drv2(1'b1, 3'b000, 32'd3, 32'd4);
    #1;
    check("l1_c0_stall", 32'(bus2.stall), 32'd0);
    tick();
    drv2(1'b1, 3'b000, 32'd5, 32'd6);
    #1;
    check("l1_c1_busy", 32'(bus2.busy), 32'd1);
    check("l1_c1_stall", 32'(bus2.stall), 32'd1);
    check("l1_c1_src_a", bus2.src_a, 32'd3);
    tick();
    #1;
    check("l1_c2_busy", 32'(bus2.busy), 32'd0);
    check("l1_c2_stall", 32'(bus2.stall), 32'd0);
    check("l1_c2_done", 32'(bus2.done), 32'd1);
    check("l1_c2_ctrl", 32'(bus2.mdu_ctrl), 32'd4);
    tick();
    drv2(1'b0, 3'b100, '0, '0);
    #1;
    check("l1_c3_busy", 32'(bus2.busy), 32'd1);
    check("l1_c3_src_a", bus2.src_a, 32'd5);
    check("l1_c3_done", 32'(bus2.done), 32'd0);
    tick();
    #1;
    check("l1_c4_busy", 32'(bus2.busy), 32'd0);
    check("l1_c4_done", 32'(bus2.done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
